// File: rtl/mdc_mac_stream_unit.sv
// Multiply / multiply-accumulate stream unit: three operand FIFOs, a kernel FSM and a one-entry output slot.
// Optional MDC_MAC_STATUS_EN adds the status_results / status_stall counters.

module mdc_mac_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         wr,
  input  logic [W-1:0] din,
  input  logic         rd,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;

  // A full FIFO still takes a write when its head leaves in the same cycle.
  assign push  = wr & (~full | rd);
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (rd)   rd_ptr <= rd_ptr + AW'(1);
      case ({push, rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= din;
  end
endmodule

module mdc_mac_stream_unit #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 64,
  parameter int ACC_W      = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] inStream0_data,
  input  logic              inStream0_wr,
  output logic              inStream0_full,
  input  logic [DATA_W-1:0] inStream1_data,
  input  logic              inStream1_wr,
  output logic              inStream1_full,
  input  logic [DATA_W-1:0] inStream2_data,
  input  logic              inStream2_wr,
  output logic              inStream2_full,
  output logic [DATA_W-1:0] outStream0_data,
  output logic              outStream0_wr,
  input  logic              outStream0_full,
  input  logic [31:0]       reg_simple_mul,
  input  logic [7:0]        reg_shift,
  input  logic [15:0]       reg_len
`ifdef MDC_MAC_STATUS_EN
  ,
  output logic [31:0]       status_results,
  output logic [31:0]       status_stall
`endif
);
  typedef enum logic [1:0] {IDLE, ACC, FIN} state_t;

  state_t state, state_next;

  logic [DATA_W-1:0] a_head, b_head, c_head;
  logic a_empty, b_empty, c_empty;
  logic pop_a, pop_b, pop_c;

  logic signed [ACC_W-1:0] acc;
  logic [15:0]             pair_cnt;
  logic [15:0]             last_idx;
  logic [7:0]              job_shift;
  logic [15:0]             job_len;

  logic              slot_valid;
  logic [DATA_W-1:0] slot_data;
  logic              slot_ready;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    c_ext;
  logic signed [ACC_W-1:0]    simple_shifted;
  logic signed [ACC_W-1:0]    fin_sum;

  logic              sample_job, acc_clear, acc_add, load_slot;
  logic [DATA_W-1:0] load_data;
  logic              unused_bits;

  mdc_mac_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) fifo_a (
    .clock(clock), .reset(reset), .wr(inStream0_wr), .din(inStream0_data),
    .rd(pop_a), .head(a_head), .full(inStream0_full), .empty(a_empty)
  );

  mdc_mac_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) fifo_b (
    .clock(clock), .reset(reset), .wr(inStream1_wr), .din(inStream1_data),
    .rd(pop_b), .head(b_head), .full(inStream1_full), .empty(b_empty)
  );

  mdc_mac_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) fifo_c (
    .clock(clock), .reset(reset), .wr(inStream2_wr), .din(inStream2_data),
    .rd(pop_c), .head(c_head), .full(inStream2_full), .empty(c_empty)
  );

  // Shifts of 2*DATA_W or more collapse to pure sign fill regardless of ACC_W.
  function automatic logic signed [ACC_W-1:0] shift_sat(input logic signed [ACC_W-1:0] v,
                                                       input logic [7:0] s);
    logic [31:0] s_wide;
    s_wide = {24'd0, s};
    if (s_wide >= 32'(2*DATA_W)) shift_sat = {ACC_W{v[ACC_W-1]}};
    else                         shift_sat = v >>> s;
  endfunction

  assign prod           = $signed(a_head) * $signed(b_head);
  assign prod_ext       = ACC_W'(prod);
  assign c_ext          = ACC_W'($signed(c_head));
  assign simple_shifted = shift_sat(prod_ext, reg_shift);
  assign fin_sum        = shift_sat(acc, job_shift) + c_ext;
  assign last_idx       = (job_len == 16'd0) ? 16'd0 : job_len - 16'd1;

  assign slot_ready      = ~slot_valid | ~outStream0_full;
  assign outStream0_wr   = slot_valid & ~outStream0_full;
  assign outStream0_data = slot_data;

  assign unused_bits = ^{reg_simple_mul[31:1], simple_shifted[ACC_W-1:DATA_W], fin_sum[ACC_W-1:DATA_W]};

  always_comb begin
    state_next = state;
    pop_a      = 1'b0;
    pop_b      = 1'b0;
    pop_c      = 1'b0;
    sample_job = 1'b0;
    acc_clear  = 1'b0;
    acc_add    = 1'b0;
    load_slot  = 1'b0;
    load_data  = '0;
    case (state)
      IDLE: begin
        sample_job = 1'b1;
        if (reg_simple_mul[0]) begin
          if (!a_empty && !b_empty && slot_ready) begin
            pop_a     = 1'b1;
            pop_b     = 1'b1;
            load_slot = 1'b1;
            load_data = simple_shifted[DATA_W-1:0];
          end
        end else begin
          acc_clear  = 1'b1;
          state_next = ACC;
        end
      end
      ACC: begin
        if (!a_empty && !b_empty) begin
          pop_a   = 1'b1;
          pop_b   = 1'b1;
          acc_add = 1'b1;
          if (pair_cnt == last_idx) state_next = FIN;
        end
      end
      FIN: begin
        if (!c_empty && slot_ready) begin
          pop_c      = 1'b1;
          load_slot  = 1'b1;
          load_data  = fin_sum[DATA_W-1:0];
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      pair_cnt  <= '0;
      job_shift <= '0;
      job_len   <= '0;
    end else begin
      state <= state_next;
      if (sample_job) begin
        job_shift <= reg_shift;
        job_len   <= reg_len;
      end
      if (acc_clear) begin
        acc      <= '0;
        pair_cnt <= '0;
      end else if (acc_add) begin
        acc      <= acc + prod_ext;
        pair_cnt <= pair_cnt + 16'd1;
      end
    end
  end

  // The slot may be refilled in the very cycle it drains.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_valid <= 1'b0;
      slot_data  <= '0;
    end else if (load_slot) begin
      slot_valid <= 1'b1;
      slot_data  <= load_data;
    end else if (outStream0_wr) begin
      slot_valid <= 1'b0;
    end
  end

`ifdef MDC_MAC_STATUS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      status_results <= '0;
      status_stall   <= '0;
    end else begin
      if (outStream0_wr)                   status_results <= status_results + 32'd1;
      if (slot_valid && outStream0_full)   status_stall   <= status_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mdc_mac_stream_unit.sv
// Scoreboard bench for mdc_mac_stream_unit: expected results queued at stimulus time, compared as the DUT emits them.
// Status counter checks are included when MDC_MAC_STATUS_EN is defined.

module tb_mdc_mac_stream_unit;
  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 64;
  localparam int ACC_W      = 64;

  logic              clock = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] inStream0_data, inStream1_data, inStream2_data;
  logic              inStream0_wr, inStream1_wr, inStream2_wr;
  logic              inStream0_full, inStream1_full, inStream2_full;
  logic [DATA_W-1:0] outStream0_data;
  logic              outStream0_wr;
  logic              outStream0_full;
  logic [31:0]       reg_simple_mul;
  logic [7:0]        reg_shift;
  logic [15:0]       reg_len;
`ifdef MDC_MAC_STATUS_EN
  logic [31:0]       status_results;
  logic [31:0]       status_stall;
`endif

  int n_compared   = 0;
  int n_mismatched = 0;
  int cyc          = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int          got_cyc[$];

  mdc_mac_stream_unit #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .ACC_W(ACC_W)) dut (
    .clock(clock), .reset(reset),
    .inStream0_data(inStream0_data), .inStream0_wr(inStream0_wr), .inStream0_full(inStream0_full),
    .inStream1_data(inStream1_data), .inStream1_wr(inStream1_wr), .inStream1_full(inStream1_full),
    .inStream2_data(inStream2_data), .inStream2_wr(inStream2_wr), .inStream2_full(inStream2_full),
    .outStream0_data(outStream0_data), .outStream0_wr(outStream0_wr), .outStream0_full(outStream0_full),
    .reg_simple_mul(reg_simple_mul), .reg_shift(reg_shift), .reg_len(reg_len)
`ifdef MDC_MAC_STATUS_EN
    , .status_results(status_results), .status_stall(status_stall)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  // Output monitor: records every transfer with the cycle it happened in.
  always @(negedge clock) begin
    if (reset === 1'b0 && outStream0_wr === 1'b1) begin
      got_q.push_back(outStream0_data);
      got_cyc.push_back(cyc);
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] model_mul(input logic [31:0] a, input logic [31:0] b, input int s);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    if (s >= 64) p = (p < 0) ? -1 : 0;
    else         p = p >>> s;
    return p[31:0];
  endfunction

  function automatic logic [31:0] model_fin(input longint acc, input int s, input logic [31:0] c);
    longint r;
    if (s >= 64) r = (acc < 0) ? -1 : 0;
    else         r = acc >>> s;
    r = r + longint'($signed(c));
    return r[31:0];
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs;
    inStream0_wr = 1'b0; inStream1_wr = 1'b0; inStream2_wr = 1'b0;
    inStream0_data = '0; inStream1_data = '0; inStream2_data = '0;
    outStream0_full = 1'b0;
    reg_simple_mul = 32'd1; reg_shift = 8'd0; reg_len = 16'd0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic wr_ab(input logic [31:0] a, input logic [31:0] b);
    inStream0_data = a; inStream0_wr = 1'b1;
    inStream1_data = b; inStream1_wr = 1'b1;
    tick();
    inStream0_wr = 1'b0; inStream1_wr = 1'b0;
  endtask

  task automatic wr_c(input logic [31:0] c);
    inStream2_data = c; inStream2_wr = 1'b1;
    tick();
    inStream2_wr = 1'b0;
  endtask

  task automatic wait_outputs(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (got_q.size() >= n) ok = 1'b1;
      else @(negedge clock);
    end
    if (got_q.size() >= n) ok = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clock);
    n_compared++; if (inStream0_full !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_full0 got=%b want=0", inStream0_full); end
    n_compared++; if (inStream1_full !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_full1 got=%b want=0", inStream1_full); end
    n_compared++; if (inStream2_full !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_full2 got=%b want=0", inStream2_full); end
    n_compared++; if (outStream0_wr !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_wr got=%b want=0", outStream0_wr); end
    n_compared++; if (outStream0_data !== 32'd0) begin n_mismatched++; $display("[TB] FAIL reset_data got=%h want=0", outStream0_data); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_simple;
    bit ok;
    logic [31:0] g, e;
    reg_simple_mul = 32'd1; reg_shift = 8'd0;
    wr_c(32'd10);
    wr_ab(32'd3, 32'hFFFF_FFFC);
    exp_q.push_back(32'hFFFF_FFF4);
    @(negedge clock);
    n_compared++; if (outStream0_wr !== 1'b0) begin n_mismatched++; $display("[TB] FAIL simple_early_wr got=%b want=0", outStream0_wr); end
    @(negedge clock);
    n_compared++; if (outStream0_wr !== 1'b1) begin n_mismatched++; $display("[TB] FAIL simple_latency_wr got=%b want=1", outStream0_wr); end
    wait_outputs(1, 5, ok);
    n_compared++;
    if (!ok) begin
      n_mismatched++; $display("[TB] FAIL simple_timeout got=%0d outputs want=1", got_q.size());
    end else begin
      g = got_q.pop_front(); e = exp_q.pop_front(); void'(got_cyc.pop_front());
      n_compared++; if (g !== e) begin n_mismatched++; $display("[TB] FAIL simple_data got=%h want=%h", g, e); end
    end
    repeat (5) @(negedge clock);
    n_compared++; if (got_q.size() !== 0) begin n_mismatched++; $display("[TB] FAIL simple_single_wr got=%0d extra want=0", got_q.size()); end
  endtask

  // Relies on the c=10 left behind by test_simple: the simple kernel must not have consumed it.
  task automatic test_mac;
    bit ok;
    logic [31:0] g, e;
    reg_shift = 8'd1; reg_len = 16'd4; reg_simple_mul = 32'd0;
    tick();
    for (int i = 0; i < 4; i++) wr_ab(32'(i + 1), 32'(i + 5));
    exp_q.push_back(32'd45);
    wait_outputs(1, 60, ok);
    n_compared++;
    if (!ok) begin
      n_mismatched++; $display("[TB] FAIL mac_timeout got=%0d outputs want=1", got_q.size());
    end else begin
      g = got_q.pop_front(); e = exp_q.pop_front(); void'(got_cyc.pop_front());
      n_compared++; if (g !== e) begin n_mismatched++; $display("[TB] FAIL mac_data got=%0d want=%0d", g, e); end
    end
    repeat (10) @(negedge clock);
    n_compared++; if (got_q.size() !== 0) begin n_mismatched++; $display("[TB] FAIL mac_single_wr got=%0d extra want=0", got_q.size()); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int sh_tab[8] = '{0, 1, 7, 31, 32, 63, 64, 200};
    logic [31:0] ext_tab[4] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0001_0003};
    logic [31:0] a, b, g, e;
    int cyc_arr[24];
    do_reset();
    for (int k = 0; k < 8; k++) begin
      reg_shift = 8'(sh_tab[k]);
      for (int j = 0; j < 3; j++) begin
        if (j == 0) begin a = ext_tab[k % 4]; b = ext_tab[(k + 1) % 4]; end
        else        begin a = $urandom; b = $urandom; end
        exp_q.push_back(model_mul(a, b, sh_tab[k]));
        wr_ab(a, b);
      end
      repeat (4) tick();
    end
    wait_outputs(24, 30, ok);
    n_compared++;
    if (!ok) begin
      n_mismatched++; $display("[TB] FAIL b2b_timeout got=%0d outputs want=24", got_q.size());
    end else begin
      for (int i = 0; i < 24; i++) begin
        g = got_q.pop_front(); e = exp_q.pop_front(); cyc_arr[i] = got_cyc.pop_front();
        n_compared++; if (g !== e) begin n_mismatched++; $display("[TB] FAIL b2b_data[%0d] got=%h want=%h", i, g, e); end
      end
      for (int k = 0; k < 8; k++) begin
        n_compared++;
        if (cyc_arr[3*k+2] - cyc_arr[3*k] !== 2) begin
          n_mismatched++; $display("[TB] FAIL b2b_throughput[%0d] got=%0d cycles want=2", k, cyc_arr[3*k+2] - cyc_arr[3*k]);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    logic [31:0] g, e;
    int c_first;
`ifdef MDC_MAC_STATUS_EN
    logic [31:0] s0;
`endif
    do_reset();
    outStream0_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(model_mul(32'(i + 2), 32'(-(i * 3) - 1), 0));
      wr_ab(32'(i + 2), 32'(-(i * 3) - 1));
    end
    repeat (3) tick();
    @(negedge clock);
`ifdef MDC_MAC_STATUS_EN
    s0 = status_stall;
`endif
    repeat (10) @(negedge clock);
`ifdef MDC_MAC_STATUS_EN
    n_compared++; if (status_stall - s0 !== 32'd10) begin n_mismatched++; $display("[TB] FAIL bp_stall_count got=%0d want=10", status_stall - s0); end
`endif
    n_compared++; if (got_q.size() !== 0) begin n_mismatched++; $display("[TB] FAIL bp_hold_wr got=%0d outputs want=0", got_q.size()); end
    @(posedge clock); #1;
    outStream0_full = 1'b0;
    wait_outputs(5, 20, ok);
    n_compared++;
    if (!ok) begin
      n_mismatched++; $display("[TB] FAIL bp_timeout got=%0d outputs want=5", got_q.size());
    end else begin
      c_first = got_cyc[0];
      for (int i = 0; i < 5; i++) begin
        g = got_q.pop_front(); e = exp_q.pop_front();
        n_compared++; if (g !== e) begin n_mismatched++; $display("[TB] FAIL bp_data[%0d] got=%h want=%h", i, g, e); end
        n_compared++; if (got_cyc[0] - c_first !== i) begin n_mismatched++; $display("[TB] FAIL bp_consecutive[%0d] got=%0d want=%0d", i, got_cyc[0] - c_first, i); end
        void'(got_cyc.pop_front());
      end
    end
    repeat (3) @(negedge clock);
`ifdef MDC_MAC_STATUS_EN
    n_compared++; if (status_results !== 32'd5) begin n_mismatched++; $display("[TB] FAIL bp_results_count got=%0d want=5", status_results); end
`endif
  endtask

  task automatic test_fifo_full;
    bit ok;
    logic [31:0] g, e;
    do_reset();
    for (int i = 0; i < 65; i++) begin
      inStream0_data = 32'(1000 + i); inStream0_wr = 1'b1;
      tick();
      if (i == 62) begin
        n_compared++; if (inStream0_full !== 1'b0) begin n_mismatched++; $display("[TB] FAIL full_after_63 got=%b want=0", inStream0_full); end
      end
      if (i == 63) begin
        n_compared++; if (inStream0_full !== 1'b1) begin n_mismatched++; $display("[TB] FAIL full_after_64 got=%b want=1", inStream0_full); end
      end
    end
    inStream0_wr = 1'b0;
    for (int i = 0; i < 64; i++) exp_q.push_back(32'(1000 + i));
    for (int i = 0; i < 65; i++) begin
      inStream1_data = 32'd1; inStream1_wr = 1'b1;
      tick();
    end
    inStream1_wr = 1'b0;
    wait_outputs(64, 20, ok);
    n_compared++;
    if (!ok) begin
      n_mismatched++; $display("[TB] FAIL full_drain_timeout got=%0d outputs want=64", got_q.size());
    end else begin
      for (int i = 0; i < 64; i++) begin
        g = got_q.pop_front(); e = exp_q.pop_front(); void'(got_cyc.pop_front());
        n_compared++; if (g !== e) begin n_mismatched++; $display("[TB] FAIL full_drain[%0d] got=%0d want=%0d", i, g, e); end
      end
    end
    repeat (6) @(negedge clock);
    n_compared++; if (got_q.size() !== 0) begin n_mismatched++; $display("[TB] FAIL full_drain_exact got=%0d extra want=0", got_q.size()); end
    n_compared++; if (inStream0_full !== 1'b0) begin n_mismatched++; $display("[TB] FAIL full_cleared got=%b want=0", inStream0_full); end
  endtask

  task automatic test_len_zero;
    bit ok;
    logic [31:0] g, e;
    logic [31:0] a_tab[3] = '{32'hFFFF_FFF7, 32'd20, 32'd11};
    logic [31:0] b_tab[3] = '{32'd13, 32'hFFFF_FFF9, 32'd4};
    longint acc;
    do_reset();
    reg_len = 16'd0; reg_shift = 8'd0; reg_simple_mul = 32'd0;
    tick();
    wr_ab(32'd7, 32'd6);
    wr_c(32'd0);
    exp_q.push_back(32'd42);
    wait_outputs(1, 20, ok);
    n_compared++;
    if (!ok) begin
      n_mismatched++; $display("[TB] FAIL len0_timeout got=%0d outputs want=1", got_q.size());
    end else begin
      g = got_q.pop_front(); e = exp_q.pop_front(); void'(got_cyc.pop_front());
      n_compared++; if (g !== e) begin n_mismatched++; $display("[TB] FAIL len0_data got=%0d want=%0d", g, e); end
    end

    do_reset();
    reg_len = 16'd3; reg_shift = 8'd2; reg_simple_mul = 32'd0;
    tick();
    acc = 0;
    for (int i = 0; i < 3; i++) acc += longint'($signed(a_tab[i])) * longint'($signed(b_tab[i]));
    exp_q.push_back(model_fin(acc, 2, 32'd5));
    wr_ab(a_tab[0], b_tab[0]);
    repeat (3) tick();
    reg_len = 16'd1;
    wr_ab(a_tab[1], b_tab[1]);
    wr_ab(a_tab[2], b_tab[2]);
    wr_c(32'd5);
    wait_outputs(1, 30, ok);
    n_compared++;
    if (!ok) begin
      n_mismatched++; $display("[TB] FAIL len_change_timeout got=%0d outputs want=1", got_q.size());
    end else begin
      g = got_q.pop_front(); e = exp_q.pop_front(); void'(got_cyc.pop_front());
      n_compared++; if (g !== e) begin n_mismatched++; $display("[TB] FAIL len_change_data got=%h want=%h", g, e); end
    end
    repeat (6) @(negedge clock);
    n_compared++; if (got_q.size() !== 0) begin n_mismatched++; $display("[TB] FAIL len_change_single got=%0d extra want=0", got_q.size()); end
  endtask

  task automatic test_reset_mid_mac;
    bit ok;
    logic [31:0] g, e;
    logic [31:0] a_tab[4] = '{32'd2, 32'hFFFF_FFFD, 32'd4, 32'd5};
    logic [31:0] b_tab[4] = '{32'd6, 32'd7, 32'hFFFF_FFF8, 32'd9};
    longint acc;
    do_reset();
    wr_ab(32'd5, 32'd5);
    wait_outputs(1, 10, ok);
    n_compared++;
    if (!ok) begin
      n_mismatched++; $display("[TB] FAIL rmid_pre_timeout got=%0d outputs want=1", got_q.size());
    end else begin
      g = got_q.pop_front(); void'(got_cyc.pop_front());
      n_compared++; if (g !== 32'd25) begin n_mismatched++; $display("[TB] FAIL rmid_pre_data got=%0d want=25", g); end
    end
    tick();
    reg_len = 16'd4; reg_simple_mul = 32'd0;
    tick();
    wr_ab(32'd100, 32'd100);
    wr_ab(32'd200, 32'd200);
    wr_c(32'd99);
    repeat (2) tick();
    reset = 1'b1;
    @(negedge clock);
    n_compared++; if (outStream0_data !== 32'd0) begin n_mismatched++; $display("[TB] FAIL rmid_data got=%h want=0", outStream0_data); end
    n_compared++; if (outStream0_wr !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rmid_wr got=%b want=0", outStream0_wr); end
    n_compared++; if (inStream2_full !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rmid_full2 got=%b want=0", inStream2_full); end
    tick();
    reset = 1'b0;
    got_q.delete(); got_cyc.delete(); exp_q.delete();
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      acc += longint'($signed(a_tab[i])) * longint'($signed(b_tab[i]));
      wr_ab(a_tab[i], b_tab[i]);
    end
    wr_c(32'd1);
    exp_q.push_back(model_fin(acc, 0, 32'd1));
    wait_outputs(1, 30, ok);
    n_compared++;
    if (!ok) begin
      n_mismatched++; $display("[TB] FAIL rmid_post_timeout got=%0d outputs want=1", got_q.size());
    end else begin
      g = got_q.pop_front(); e = exp_q.pop_front(); void'(got_cyc.pop_front());
      n_compared++; if (g !== e) begin n_mismatched++; $display("[TB] FAIL rmid_post_data got=%0d want=%0d", g, e); end
    end
  endtask

  initial begin
    test_reset();
    test_simple();
    test_mac();
    test_back_to_back();
    test_backpressure();
    test_fifo_full();
    test_len_zero();
    test_reset_mid_mac();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule

// File: doc/mdc_mac_stream_unit.md
# mdc_mac_stream_unit

Parametrised successor of the single-actor multiply/MAC dataflow network. It integrates three operand input FIFOs, a mode-selectable multiply / multiply-accumulate kernel with arithmetic shift, and a registered output stage driving a full-flagged stream. It sits between the accelerator stream adapters and the downstream sink, with dynamic parameters supplied from the register file.

## Interface
Parameters:
- DATA_W, 32, width of every data stream and of the result
- FIFO_DEPTH, 64, entries per input FIFO; power of two, >= 2
- ACC_W, 64, signed accumulator width; must be >= 2*DATA_W

Ports:
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- inStream0_data  in  DATA_W  operand a
- inStream0_wr  in  1  write strobe for a
- inStream0_full  out  1  a FIFO full
- inStream1_data / inStream1_wr / inStream1_full  same as above, for operand b
- inStream2_data / inStream2_wr / inStream2_full  same as above, for addend c
- outStream0_data  out  DATA_W  result
- outStream0_wr  out  1  result transfer strobe
- outStream0_full  in  1  downstream cannot accept
- reg_simple_mul  in  32  bit 0: 1 = simple multiply mode, 0 = MAC mode; bits 31:1 ignored
- reg_shift  in  8  arithmetic right shift; values >= 2*DATA_W saturate to sign fill
- reg_len  in  16  MAC length in a/b pairs; 0 is treated as 1

## Operation
- Input FIFOs: a write is accepted when wr=1 and full=0. A wr while full is dropped and leaves contents unchanged. full=1 iff count==FIFO_DEPTH. A read and a write in the same cycle on a full FIFO are both accepted. All values are signed two's complement.
- Kernel FSM states: IDLE, ACC, FIN.
  - IDLE: sample reg_simple_mul[0], reg_shift and reg_len into job registers. Those registers are held for the whole job; changes mid-job take effect at the next IDLE.
  - Simple mode (from IDLE, stays IDLE): fires when a and b are both non-empty and the output slot is free or draining this cycle. It pops one a and one b. The result is (a*b >>> shift)[DATA_W-1:0]. c is never consumed.
  - MAC mode: IDLE clears acc and enters ACC.
  - ACC: each cycle with a and b both non-empty, pop both, add sign-extended a*b to acc (wraps modulo 2^ACC_W), and increment the pair count. After the len-th pair, go to FIN.
  - FIN: fires when c is non-empty and the output slot is free or draining. It pops c, produces ((acc >>> shift) + sext(c))[DATA_W-1:0], then returns to IDLE.
- Output slot: a one-entry register. outStream0_wr = slot_valid & ~outStream0_full, and a transfer occurs in that cycle. The slot can be refilled in the same cycle it drains.

## Timing
- Reset values: inStream*_full=0, outStream0_wr=0, outStream0_data=0, FSM=IDLE, acc=0, FIFOs empty, slot empty.
- FIFO: a write at edge t makes the entry visible to the kernel at cycle t+1.
- Simple mode: kernel fire at cycle t gives the result in the slot and wr=1 at cycle t+1 (when not full). Sustained throughput is 1 result per cycle with no backpressure.
- MAC mode with operands pre-loaded: 1 IDLE cycle + len ACC cycles + 1 FIN cycle, then the result appears in the slot the following cycle. Total latency is len+3 cycles from leaving the previous job.
- Backpressure: while outStream0_full=1 and the slot is valid, no kernel firing occurs. Data stays stable and wr stays 0.
- Reset asserted mid-job discards the FIFOs, acc and the slot immediately. The first write after deassertion is accepted on the next edge.

## Configuration
- MDC_MAC_STATUS_EN defined: adds output port status_results [31:0], which counts completed output transfers, and output port status_stall [31:0], which counts cycles with slot_valid & outStream0_full. Both counters wrap and reset to 0.
- Not defined: both ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Simple mode, shift=0: write a=3, b=-4 -> one outStream0_wr with data 0xFFFFFFF4 two cycles after the writes; c FIFO untouched.
- MAC mode, len=4, shift=1: a={1,2,3,4}, b={5,6,7,8}, c=10 -> single output (70>>>1)+10 = 45; exactly one wr.
- Backpressure: simple mode, outStream0_full held high for 10 cycles with 5 pairs queued -> no wr during the hold; then 5 results in order on consecutive cycles; with MDC_MAC_STATUS_EN, status_stall=10 and status_results=5.
- FIFO full: 65 writes to inStream0 with no reads (depth 64) -> full=1 after the 64th; the 65th is dropped; the FIFO later drains exactly 64 values.
- reg_len=0 in MAC mode: a=7, b=6, c=0, shift=0 -> output 42; changing reg_len during ACC does not alter the current job.
- Reset mid-MAC after 2 of 4 pairs -> all outputs return to 0; a new full job afterward yields the correct result.
